// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: source select and write request.
package wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Bit 0 is tied low; a same-cycle set wins over clear.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] rd_a_idx,
    input  logic [REG_ADDR_W-1:0] rd_b_idx,
    input  logic [REG_ADDR_W-1:0] rd_c_idx,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  busy_c
);

    logic [31:0] pend_q;
    logic [31:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_idx] = 1'b0;
        if (set_en) pend_d[set_idx] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign busy_a = pend_q[rd_a_idx];
    assign busy_b = pend_q[rd_b_idx];
    assign busy_c = pend_q[rd_c_idx];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/LSU merge into one registered write port, with
// scoreboard and operand bypass. Define WB_PERF_EN for perf counters.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       reg_rs1_value,
    input  logic [XLEN-1:0]       reg_rs2_value,
    output logic [XLEN-1:0]       rs1_fwd_value,
    output logic [XLEN-1:0]       rs2_fwd_value,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
`ifdef WB_PERF_EN
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic                  write_regf_en,
    output logic [REG_ADDR_W-1:0] addr_rd,
    output logic [XLEN-1:0]       rd_value
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       val_q, val_d;
    logic                  starve;
    logic                  lsu_acc;
    wb_src_e               src;
    wb_req_t               req;

    // Once the LSU has waited long enough it takes the port for one cycle.
    assign starve    = (cnt_q == LIMIT);
    assign alu_ready = !starve;
    assign lsu_ready = starve || !alu_valid;
    assign lsu_acc   = lsu_valid && lsu_ready;

    always_comb begin
        src = WB_NONE;
        if (starve) begin
            if (lsu_valid) src = WB_LSU;
        end else if (alu_valid) begin
            src = WB_ALU;
        end else if (lsu_valid) begin
            src = WB_LSU;
        end
    end

    always_comb begin
        req = '0;
        unique case (src)
            WB_ALU:  req = '{rd: alu_rd, data: alu_data};
            WB_LSU:  req = '{rd: lsu_rd, data: lsu_data};
            default: req = '0;
        endcase
    end

    always_comb begin
        cnt_d  = '0;
        wen_d  = 1'b0;
        addr_d = addr_q;
        val_d  = val_q;
        if (!starve && lsu_valid && !lsu_ready) cnt_d = cnt_q + 4'd1;
        if (src != WB_NONE) begin
            wen_d  = (req.rd != '0);
            addr_d = req.rd;
            val_d  = req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            val_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            val_q  <= val_d;
        end
    end

    assign write_regf_en = wen_q;
    assign addr_rd       = addr_q;
    assign rd_value      = val_q;

    assign rs1_fwd_value = (wen_q && addr_q == rs1_addr && rs1_addr != '0)
                           ? val_q : reg_rs1_value;
    assign rs2_fwd_value = (wen_q && addr_q == rs2_addr && rs2_addr != '0)
                           ? val_q : reg_rs2_value;

    wb_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_valid && issue_long && issue_rd != '0),
        .set_idx  (issue_rd),
        .clr_en   (lsu_acc),
        .clr_idx  (lsu_rd),
        .rd_a_idx (rs1_addr),
        .rd_b_idx (rs2_addr),
        .rd_c_idx (issue_rd),
        .busy_a   (rs1_busy),
        .busy_b   (rs2_busy),
        .busy_c   (rd_busy)
    );

`ifdef WB_PERF_EN
    logic [31:0] pwr_q, pwr_d;
    logic [31:0] pst_q, pst_d;

    always_comb begin
        pwr_d = pwr_q + {31'd0, wen_q};
        pst_d = pst_q + {31'd0, (lsu_valid && !lsu_ready)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_q <= '0;
            pst_q <= '0;
        end else begin
            pwr_q <= pwr_d;
            pst_q <= pst_d;
        end
    end

    assign perf_wr_cnt    = pwr_q;
    assign perf_stall_cnt = pst_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] reg_rs1_value, reg_rs2_value;
    logic [31:0] rs1_fwd_value, rs2_fwd_value;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        write_regf_en;
    logic [4:0]  addr_rd;
    logic [31:0] rd_value;
`ifdef WB_PERF_EN
    logic [31:0] perf_wr_cnt, perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .issue_valid   (issue_valid),
        .issue_long    (issue_long),
        .issue_rd      (issue_rd),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .reg_rs1_value (reg_rs1_value),
        .reg_rs2_value (reg_rs2_value),
        .rs1_fwd_value (rs1_fwd_value),
        .rs2_fwd_value (rs2_fwd_value),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rd_busy       (rd_busy),
`ifdef WB_PERF_EN
        .perf_wr_cnt   (perf_wr_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .write_regf_en (write_regf_en),
        .addr_rd       (addr_rd),
        .rd_value      (rd_value)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
        reg_rs1_value = 0; reg_rs2_value = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_wen", {31'd0, write_regf_en}, 0);
        check("rst_addr", {27'd0, addr_rd}, 0);
        check("rst_val", rd_value, 0);
        check("rst_alu_rdy", {31'd0, alu_ready}, 1);
        check("rst_lsu_rdy", {31'd0, lsu_ready}, 1);

        // ALU-only write and same-cycle bypass
        tick();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("alu_rdy", {31'd0, alu_ready}, 1);
        tick();
        alu_valid = 0;
        rs1_addr = 5; reg_rs1_value = 32'h11111111;
        rs2_addr = 6; reg_rs2_value = 32'h22222222;
        #1;
        check("alu_wen", {31'd0, write_regf_en}, 1);
        check("alu_addr", {27'd0, addr_rd}, 5);
        check("alu_val", rd_value, 32'hDEADBEEF);
        check("byp_rs1", rs1_fwd_value, 32'hDEADBEEF);
        check("byp_rs2", rs2_fwd_value, 32'h22222222);

        // Simultaneous valid: ALU first, then LSU
        tick();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA3;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hB7;
        #1;
        check("sim_lsu_rdy", {31'd0, lsu_ready}, 0);
        check("sim_alu_rdy", {31'd0, alu_ready}, 1);
        tick();
        alu_valid = 0;
        #1;
        check("sim_addr3", {27'd0, addr_rd}, 3);
        check("sim_lsu_rdy2", {31'd0, lsu_ready}, 1);
        tick();
        lsu_valid = 0;
        #1;
        check("sim_addr7", {27'd0, addr_rd}, 7);
        check("sim_val7", rd_value, 32'hB7);
        check("sim_wen7", {31'd0, write_regf_en}, 1);
        tick();
        #1 check("idle_wen", {31'd0, write_regf_en}, 0);

        // Starvation: both held high
        alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("stv_lsu_rdy%0d", i), {31'd0, lsu_ready},
                  (i % 5 == 4) ? 1 : 0);
            check($sformatf("stv_alu_rdy%0d", i), {31'd0, alu_ready},
                  (i % 5 == 4) ? 0 : 1);
            tick();
            #1;
            check($sformatf("stv_addr%0d", i), {27'd0, addr_rd},
                  (i % 5 == 4) ? 9 : 8);
        end
        alu_valid = 0; lsu_valid = 0;
        tick();

        // Scoreboard set then clear
        issue_valid = 1; issue_long = 1; issue_rd = 10;
        rs1_addr = 10; reg_rs1_value = 32'h0;
        #1;
        check("sb_pre", {31'd0, rs1_busy}, 0);
        check("sb_rd_pre", {31'd0, rd_busy}, 0);
        tick();
        issue_valid = 0;
        #1;
        check("sb_set", {31'd0, rs1_busy}, 1);
        check("sb_rd_set", {31'd0, rd_busy}, 1);
        tick();
        lsu_valid = 1; lsu_rd = 10; lsu_data = 32'h55;
        #1;
        check("sb_acc_rdy", {31'd0, lsu_ready}, 1);
        check("sb_acc_busy", {31'd0, rs1_busy}, 1);
        tick();
        lsu_valid = 0;
        #1;
        check("sb_clr", {31'd0, rs1_busy}, 0);
        check("sb_byp", rs1_fwd_value, 32'h55);

        // Same-cycle set and clear: set wins
        issue_valid = 1;
        tick();
        lsu_valid = 1;
        tick();
        issue_valid = 0; lsu_valid = 0;
        #1 check("sb_set_wins", {31'd0, rs1_busy}, 1);
        lsu_valid = 1;
        tick();
        lsu_valid = 0;
        #1 check("sb_clr2", {31'd0, rs1_busy}, 0);

        // rd=0 result
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        #1 check("rd0_rdy", {31'd0, alu_ready}, 1);
        tick();
        alu_valid = 0;
        rs1_addr = 0; reg_rs1_value = 32'hCAFE;
        #1;
        check("rd0_wen", {31'd0, write_regf_en}, 0);
        check("rd0_pass", rs1_fwd_value, 32'hCAFE);

        // Reset mid-operation
        issue_valid = 1; issue_long = 1; issue_rd = 1;
        tick();
        issue_rd = 2;
        tick();
        issue_rd = 3;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        tick();
        issue_valid = 0; alu_valid = 0;
        rs1_addr = 1; rs2_addr = 3; issue_rd = 2;
        #1;
        check("mid_wen", {31'd0, write_regf_en}, 1);
        check("mid_b1", {31'd0, rs1_busy}, 1);
        check("mid_b3", {31'd0, rs2_busy}, 1);
        check("mid_b2", {31'd0, rd_busy}, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("mr_wen", {31'd0, write_regf_en}, 0);
        check("mr_addr", {27'd0, addr_rd}, 0);
        check("mr_val", rd_value, 0);
        check("mr_b1", {31'd0, rs1_busy}, 0);
        check("mr_b3", {31'd0, rs2_busy}, 0);
        check("mr_b2", {31'd0, rd_busy}, 0);
        check("mr_alu_rdy", {31'd0, alu_ready}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
